avst_pkt_sorter: RTL and testbench

- Parametrised Avalon-ST packet sorter for the sort datapath.
- Captures one packet of up to MAX_PKT_LEN words on the sink port into a register buffer.
- Sorts the buffer in place with an odd-even transposition network, one pass per cycle, in a per-packet selectable direction.
- Streams the sorted packet out on the source port under src_ready_i backpressure; handles variable packet length, truncation of over-long packets, and single-word packets.

---
 rtl/avst_pkt_sorter.sv | 133 +++++++++++++
 tb/tb_avst_pkt_sorter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_pkt_sorter.sv
// avst_pkt_sorter: captures one Avalon-ST packet, sorts it in place with an odd-even transposition
// network (one pass per cycle) and streams it back out. Define AVST_SORT_TRUNC_FLAG_EN to add trunc_o.
module avst_pkt_sorter #(
    parameter int  DWIDTH      = 10,
    parameter int  MAX_PKT_LEN = 16,
    localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    input  logic              sort_desc_i,
`ifdef AVST_SORT_TRUNC_FLAG_EN
    output logic              trunc_o,
`endif
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
);

    localparam int             IDX_W   = $clog2(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [1:0] {IDLE_S, RECV_S, SORT_S, SEND_S} state_t;

    state_t            state, state_n;
    logic [DWIDTH-1:0] mem      [MAX_PKT_LEN];
    logic [DWIDTH-1:0] pass_mem [MAX_PKT_LEN];
    logic [LEN_W-1:0]  len, idx, p;
    logic              dir, overflow;
    logic              snk_beat, src_beat;

    assign snk_beat = snk_valid_i & snk_ready_o;
    assign src_beat = src_valid_o & src_ready_i;

    // Source side is decoded straight from state so an async reset clears it without a clock edge.
    assign src_valid_o         = (state == SEND_S);
    assign src_data_o          = src_valid_o ? mem[idx[IDX_W-1:0]] : '0;
    assign src_startofpacket_o = src_valid_o && (idx == '0);
    assign src_endofpacket_o   = src_valid_o && (idx == len - ONE);

`ifdef AVST_SORT_TRUNC_FLAG_EN
    assign trunc_o = (state == RECV_S) && snk_beat && snk_endofpacket_i && !snk_startofpacket_i
                     && (overflow || (len == MAX_LEN));
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE_S: if (snk_beat && snk_startofpacket_i)
                        state_n = snk_endofpacket_i ? SORT_S : RECV_S;
            RECV_S: if (snk_beat && snk_endofpacket_i) state_n = SORT_S;
            SORT_S: if (p == len - ONE) state_n = SEND_S;
            SEND_S: if (src_beat && src_endofpacket_o) state_n = IDLE_S;
            default: state_n = IDLE_S;
        endcase
    end

    // One transposition pass: even p pairs (0,1),(2,3)..., odd p pairs (1,2),(3,4)...
    always_comb begin
        pass_mem = mem;
        for (int i = 0; i < MAX_PKT_LEN - 1; i++) begin
            if ((i[0] == p[0]) && (LEN_W'(i + 1) < len)) begin
                if (dir ? (mem[i] < mem[i+1]) : (mem[i] > mem[i+1])) begin
                    pass_mem[i]   = mem[i+1];
                    pass_mem[i+1] = mem[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE_S;
            snk_ready_o <= 1'b0;
            len         <= '0;
            idx         <= '0;
            p           <= '0;
            dir         <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            snk_ready_o <= (state_n == IDLE_S) || (state_n == RECV_S);
            case (state)
                IDLE_S: if (snk_beat && snk_startofpacket_i) begin
                    len      <= ONE;
                    dir      <= sort_desc_i;
                    overflow <= 1'b0;
                    p        <= '0;
                end
                RECV_S: if (snk_beat) begin
                    if (snk_startofpacket_i) begin
                        len      <= ONE;
                        dir      <= sort_desc_i;
                        overflow <= 1'b0;
                    end else if (len == MAX_LEN) begin
                        overflow <= 1'b1;
                    end else begin
                        len <= len + ONE;
                    end
                end
                SORT_S: if (state_n == SEND_S) begin
                    p   <= '0;
                    idx <= '0;
                end else begin
                    p <= p + ONE;
                end
                SEND_S: if (src_beat && !src_endofpacket_o) idx <= idx + ONE;
                default: ;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk_i) begin
        case (state)
            IDLE_S: if (snk_beat && snk_startofpacket_i) mem[0] <= snk_data_i;
            RECV_S: if (snk_beat) begin
                if (snk_startofpacket_i)  mem[0] <= snk_data_i;
                else if (len != MAX_LEN)  mem[len[IDX_W-1:0]] <= snk_data_i;
            end
            SORT_S: mem <= pass_mem;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_avst_pkt_sorter.sv
// Self-checking bench for avst_pkt_sorter: directed and random packets against a queue-based sort model.
// Build with AVST_SORT_TRUNC_FLAG_EN defined to also check trunc_o.
module tb_avst_pkt_sorter;

    localparam int DW   = 10;
    localparam int MAXL = 16;

    typedef logic [DW-1:0] word_t;
    typedef word_t word_q_t[$];

    logic  clk      = 1'b0;
    logic  rst_n    = 1'b0;
    word_t snkData  = '0;
    logic  snkSop   = 1'b0;
    logic  snkEop   = 1'b0;
    logic  snkValid = 1'b0;
    logic  sortDesc = 1'b0;
    logic  srcReady = 1'b1;
    logic  snkReady;
    word_t srcData;
    logic  srcSop, srcEop, srcValid;
`ifdef AVST_SORT_TRUNC_FLAG_EN
    logic  trunc;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Packet-level model: what the sorter should have accepted, and the sorted result it owes us.
    bit      mInPkt = 1'b0;
    bit      mDir   = 1'b0;
    word_q_t mPkt;
    word_q_t expQ;

    avst_pkt_sorter #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .snk_data_i          (snkData),
        .snk_startofpacket_i (snkSop),
        .snk_endofpacket_i   (snkEop),
        .snk_valid_i         (snkValid),
        .snk_ready_o         (snkReady),
        .sort_desc_i         (sortDesc),
`ifdef AVST_SORT_TRUNC_FLAG_EN
        .trunc_o             (trunc),
`endif
        .src_data_o          (srcData),
        .src_startofpacket_o (srcSop),
        .src_endofpacket_o   (srcEop),
        .src_valid_o         (srcValid),
        .src_ready_i         (srcReady)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic word_q_t sortedCopy(input word_q_t q, input bit desc);
        word_q_t r;
        foreach (q[i]) begin
            int pos;
            pos = r.size();
            for (int j = 0; j < r.size(); j++) begin
                if (desc ? (q[i] > r[j]) : (q[i] < r[j])) begin
                    pos = j;
                    break;
                end
            end
            r.insert(pos, q[i]);
        end
        return r;
    endfunction

    function automatic void modelBeat(input word_t d, input logic sop, input logic eop, input logic desc);
        if (sop) begin
            mPkt.delete();
            mPkt.push_back(d);
            mDir   = desc;
            mInPkt = 1'b1;
        end else if (mInPkt && (mPkt.size() < MAXL)) begin
            mPkt.push_back(d);
        end
        if (mInPkt && eop) begin
            expQ   = sortedCopy(mPkt, mDir);
            mInPkt = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge after the beat's clock edge.
    task automatic sendBeat(input word_t d, input logic sop, input logic eop, input logic desc);
        int guard = 0;
        snkData  = d;
        snkSop   = sop;
        snkEop   = eop;
        sortDesc = desc;
        snkValid = 1'b1;
        while (snkReady !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        expectEq("snk_ready", snkReady, 1);
`ifdef AVST_SORT_TRUNC_FLAG_EN
        expectEq("trunc_o", trunc, (mInPkt && !sop && eop && (mPkt.size() >= MAXL)) ? 1 : 0);
`endif
        modelBeat(d, sop, eop, desc);
        @(negedge clk);
        snkValid = 1'b0;
        snkSop   = 1'b0;
        snkEop   = 1'b0;
    endtask

    // The eop beat's cycle counts as 0; first valid is expected len+1 cycles later.
    task automatic checkLatency();
        int cnt = 1;
        while (!srcValid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        expectEq("latency", cnt, expQ.size() + 1);
    endtask

    task automatic checkOutput(input int readyPct);
        int k = 0;
        int guard = 0;
        while (k < expQ.size() && guard < 2000) begin
            expectEq("src_valid", srcValid, 1);
            expectEq("src_data", srcData, expQ[k]);
            expectEq("src_sop", srcSop, (k == 0) ? 1 : 0);
            expectEq("src_eop", srcEop, (k == expQ.size() - 1) ? 1 : 0);
            expectEq("snk_ready_busy", snkReady, 0);
            srcReady = ($urandom_range(99) < readyPct);
            @(negedge clk);
            guard++;
            if (srcReady) k++;
        end
        srcReady = 1'b1;
        expectEq("valid_after_eop", srcValid, 0);
        expectEq("ready_after_eop", snkReady, 1);
    endtask

    // Sends a whole packet; sort_desc_i is randomised on non-sop beats since only the sop beat counts.
    task automatic applyStimulus(input word_q_t words, input logic desc, input int readyPct);
        foreach (words[i])
            sendBeat(words[i], (i == 0), (i == words.size() - 1),
                     (i == 0) ? desc : 1'($urandom_range(1)));
        checkLatency();
        checkOutput(readyPct);
    endtask

    initial begin
        word_q_t w;

        $display("[TB] reset phase");
        repeat (2) @(negedge clk);
        expectEq("rst_snk_ready", snkReady, 0);
        expectEq("rst_src_valid", srcValid, 0);
        expectEq("rst_src_sop", srcSop, 0);
        expectEq("rst_src_eop", srcEop, 0);
        expectEq("rst_src_data", srcData, 0);
        rst_n = 1'b1;
        expectEq("ready_at_release", snkReady, 0);
        @(negedge clk);
        expectEq("ready_first_edge", snkReady, 1);

        $display("[TB] ascending 5,3,9,1");
        w.delete(); w.push_back(5); w.push_back(3); w.push_back(9); w.push_back(1);
        applyStimulus(w, 1'b0, 100);

        $display("[TB] descending single word and duplicates");
        w.delete(); w.push_back(7);
        applyStimulus(w, 1'b1, 100);
        w.delete(); w.push_back(4); w.push_back(4); w.push_back(2);
        applyStimulus(w, 1'b1, 100);

        $display("[TB] full depth under backpressure");
        w.delete();
        repeat (MAXL) w.push_back(word_t'($urandom_range(1023)));
        applyStimulus(w, 1'b0, 50);

        $display("[TB] truncation 20..1");
        w.delete();
        for (int v = 20; v >= 1; v--) w.push_back(word_t'(v));
        applyStimulus(w, 1'b0, 100);

        $display("[TB] random packets");
        for (int n = 0; n < 8; n++) begin
            int l;
            l = $urandom_range(1, 22);
            w.delete();
            repeat (l) w.push_back(word_t'($urandom_range((n % 2 == 1) ? 15 : 1023)));
            applyStimulus(w, 1'($urandom_range(1)), $urandom_range(30, 100));
        end

        $display("[TB] protocol edges");
        sendBeat(11, 1'b0, 1'b0, 1'b0);
        sendBeat(12, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expectEq("idle_drop_valid", srcValid, 0);
            expectEq("idle_drop_ready", snkReady, 1);
            @(negedge clk);
        end
        sendBeat(30, 1'b1, 1'b0, 1'b1);
        sendBeat(31, 1'b0, 1'b0, 1'b1);
        sendBeat(32, 1'b0, 1'b0, 1'b1);
        sendBeat(8,  1'b1, 1'b0, 1'b0);
        sendBeat(6,  1'b0, 1'b1, 1'b1);
        checkLatency();
        checkOutput(100);

        $display("[TB] async reset during send");
        w.delete();
        repeat (6) w.push_back(word_t'($urandom_range(1023)));
        foreach (w[i]) sendBeat(w[i], (i == 0), (i == w.size() - 1), 1'b0);
        checkLatency();
        srcReady = 1'b0;
        @(negedge clk);
        expectEq("hold_sop", srcSop, 1);
        expectEq("hold_data", srcData, expQ[0]);
        #2 rst_n = 1'b0;
        #1;
        expectEq("async_valid", srcValid, 0);
        expectEq("async_sop", srcSop, 0);
        expectEq("async_eop", srcEop, 0);
        expectEq("async_data", srcData, 0);
        expectEq("async_snk_ready", snkReady, 0);
        mInPkt = 1'b0;
        mPkt.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        srcReady = 1'b1;
        expectEq("rerelease_ready", snkReady, 0);
        @(negedge clk);
        expectEq("rerelease_ready_edge", snkReady, 1);
        w.delete(); w.push_back(300); w.push_back(2); w.push_back(1023); w.push_back(0); w.push_back(77);
        applyStimulus(w, 1'b1, 70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
